serial_adder: RTL and testbench

- Multi-cycle ripple-carry adder. It is the additive counterpart to the combinational ripple-borrow subtractor used in the core85 ALU datapath.
- Adds two DATASIZE-bit operands plus carry-in, SLICE bits per clock, LSB slice first.
- Produces sum, carry-out and the 8085 auxiliary carry (carry out of bit 3).
- Used where ALU area matters more than latency, e.g. the 16-bit DAD path and address increment.

---
 rtl/serial_adder_if.sv | 30 +++
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and result bundle for serial_adder. Defining SERIAL_ADDER_FLAGS_EN adds
// the zero/sign/parity flag outputs.
interface serial_adder_if #(
  parameter int DATASIZE = 8
);
  logic                iSTART;
  logic [DATASIZE-1:0] iA;
  logic [DATASIZE-1:0] iB;
  logic                iC;
  logic                oBUSY;
  logic                oDONE;
  logic [DATASIZE-1:0] oS;
  logic                oC;
  logic                oAC;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic                oZ;
  logic                oSG;
  logic                oPF;

  modport master (output iSTART, iA, iB, iC,
                  input  oBUSY, oDONE, oS, oC, oAC, oZ, oSG, oPF);
  modport slave  (input  iSTART, iA, iB, iC,
                  output oBUSY, oDONE, oS, oC, oAC, oZ, oSG, oPF);
`else
  modport master (output iSTART, iA, iB, iC,
                  input  oBUSY, oDONE, oS, oC, oAC);
  modport slave  (input  iSTART, iA, iB, iC,
                  output oBUSY, oDONE, oS, oC, oAC);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle ripple-carry adder, SLICE bits per clock, LSB slice first, with 8085 AC.
// Optional macro SERIAL_ADDER_FLAGS_EN adds registered Z/SG/PF flags on the bus.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int DATASIZE = 8,
  parameter int SLICE    = 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  serial_adder_if.slave bus
);
  localparam int N      = DATASIZE / SLICE;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int AC_BIT = (3 % SLICE) + 1;
  localparam bit HAS_AC = (DATASIZE >= 5);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] AC_CNT = CNT_W'(3 / SLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                start_acc, last;
  logic [DATASIZE-1:0] a_q, b_q, sum_q, sum_nxt;
  logic                cy_q, ac_q, ac_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATASIZE-1:0] s_q;
  logic                c_q, acr_q;
  logic [SLICE:0]      chain;
  logic [SLICE-1:0]    slice_sum;

  // One full-adder cell per bit of the slice forms the ripple chain.
  assign chain[0] = cy_q;
  serial_adder_fa u_fa [SLICE-1:0] (
    .a  (a_q[SLICE-1:0]),
    .b  (b_q[SLICE-1:0]),
    .ci (chain[SLICE-1:0]),
    .s  (slice_sum),
    .co (chain[SLICE:1])
  );

  assign sum_nxt = (sum_q >> SLICE) | (DATASIZE'(slice_sum) << (DATASIZE - SLICE));

  always_comb begin
    ac_nxt = ac_q;
    if (HAS_AC && state_q == RUN && cnt_q == AC_CNT) ac_nxt = chain[AC_BIT];
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.iSTART) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
      ac_q  <= 1'b0;
      cnt_q <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      acr_q <= 1'b0;
    end else begin
      if (start_acc) begin
        a_q   <= bus.iA;
        b_q   <= bus.iB;
        cy_q  <= bus.iC;
        ac_q  <= 1'b0;
        sum_q <= '0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q   <= a_q >> SLICE;
        b_q   <= b_q >> SLICE;
        cy_q  <= chain[SLICE];
        ac_q  <= ac_nxt;
        sum_q <= sum_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
      // Results change only on completion so they hold through IDLE and RUN.
      if (last) begin
        s_q   <= sum_nxt;
        c_q   <= chain[SLICE];
        acr_q <= ac_nxt;
      end
    end
  end

  assign bus.oBUSY = (state_q == RUN);
  assign bus.oDONE = (state_q == DONE);
  assign bus.oS    = s_q;
  assign bus.oC    = c_q;
  assign bus.oAC   = acr_q;

`ifdef SERIAL_ADDER_FLAGS_EN
  logic z_q, sg_q, pf_q;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      z_q  <= 1'b0;
      sg_q <= 1'b0;
      pf_q <= 1'b0;
    end else if (last) begin
      z_q  <= (sum_nxt == '0);
      sg_q <= sum_nxt[DATASIZE-1];
      pf_q <= ~^sum_nxt;
    end
  end

  assign bus.oZ  = z_q;
  assign bus.oSG = sg_q;
  assign bus.oPF = pf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Random and directed checks of serial_adder at SLICE 1/2/4/8 (8-bit) and 16-bit/SLICE 8,
// against A+B+C computed with plain arithmetic.
module tb_serial_adder;
  logic iCLK = 1'b0;
  logic iRSTn;
  always #5 iCLK = ~iCLK;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Four 8-bit DUTs sharing operands, one start line each.
  logic [3:0] start8;
  logic [7:0] a8, b8;
  logic       c8;
  logic [3:0] busy8, done8, co8, ac8;
  logic [7:0] s8 [4];
`ifdef SERIAL_ADDER_FLAGS_EN
  logic [3:0] z8, sg8, pf8;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder_if #(.DATASIZE(8)) bus ();
    assign bus.iSTART = start8[g];
    assign bus.iA     = a8;
    assign bus.iB     = b8;
    assign bus.iC     = c8;
    assign busy8[g]   = bus.oBUSY;
    assign done8[g]   = bus.oDONE;
    assign s8[g]      = bus.oS;
    assign co8[g]     = bus.oC;
    assign ac8[g]     = bus.oAC;
`ifdef SERIAL_ADDER_FLAGS_EN
    assign z8[g]      = bus.oZ;
    assign sg8[g]     = bus.oSG;
    assign pf8[g]     = bus.oPF;
`endif
    serial_adder #(.DATASIZE(8), .SLICE(1 << g)) u_dut (
      .iCLK  (iCLK),
      .iRSTn (iRSTn),
      .bus   (bus)
    );
  end

  serial_adder_if #(.DATASIZE(16)) wbus ();
  logic        w_start, w_c;
  logic [15:0] w_a, w_b;
  assign wbus.iSTART = w_start;
  assign wbus.iA     = w_a;
  assign wbus.iB     = w_b;
  assign wbus.iC     = w_c;
  serial_adder #(.DATASIZE(16), .SLICE(8)) u_wide (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (wbus)
  );

  // Last completed result per 8-bit DUT; outputs must hold this until the next completion.
  logic [7:0] exp_s  [4] = '{default: '0};
  logic       exp_c  [4] = '{default: 1'b0};
  logic       exp_ac [4] = '{default: 1'b0};

  task automatic chk_result(input int g, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] full;
    logic [4:0] lo;
    string      p;
    full = 9'(a) + 9'(b) + 9'(c);
    lo   = 5'(a[3:0]) + 5'(b[3:0]) + 5'(c);
    p    = $sformatf("s%0d_%h+%h+%0d", 1 << g, a, b, c);
    chk({p, "_sum"}, s8[g], full[7:0]);
    chk({p, "_cy"},  co8[g], full[8]);
    chk({p, "_ac"},  ac8[g], lo[4]);
`ifdef SERIAL_ADDER_FLAGS_EN
    chk({p, "_z"},  z8[g],  full[7:0] == 8'h00);
    chk({p, "_sg"}, sg8[g], full[7]);
    chk({p, "_pf"}, pf8[g], ~^full[7:0]);
`endif
    exp_s[g]  = full[7:0];
    exp_c[g]  = full[8];
    exp_ac[g] = lo[4];
  endtask

  // Run one operation on the masked DUTs; scrambles operands and optionally re-pulses
  // iSTART while they are busy.
  task automatic do_op(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input bit mid_pulse);
    int first [4];
    int ndone [4];
    int nbusy [4];
    @(negedge iCLK);
    a8 = a; b8 = b; c8 = c; start8 = mask;
    for (int g = 0; g < 4; g++) begin first[g] = -1; ndone[g] = 0; nbusy[g] = 0; end
    for (int j = 0; j < 12; j++) begin
      @(negedge iCLK);
      start8 = (mid_pulse && j == 0) ? mask : 4'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      for (int g = 0; g < 4; g++) begin
        if (mask[g]) begin
          if (j == 0) chk($sformatf("s%0d_hold", 1 << g), {s8[g], co8[g], ac8[g]},
                          {exp_s[g], exp_c[g], exp_ac[g]});
          if (busy8[g]) nbusy[g]++;
          if (done8[g]) begin
            ndone[g]++;
            if (first[g] < 0) first[g] = j;
          end
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      if (mask[g]) begin
        chk($sformatf("s%0d_latency", 1 << g), first[g], 8 >> g);
        chk($sformatf("s%0d_busy_cycles", 1 << g), nbusy[g], 8 >> g);
        chk($sformatf("s%0d_done_pulses", 1 << g), ndone[g], 1);
        chk_result(g, a, b, c);
      end
    end
  endtask

  // Clears start on the first negedge, returns the negedge count at which oDONE appears (0 = timeout).
  task automatic wait_done(input int g, output int n, output logic busy0, output logic [7:0] s0);
    n = 0; busy0 = 1'b0; s0 = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge iCLK);
      start8[g] = 1'b0;
      if (i == 1) begin busy0 = busy8[g]; s0 = s8[g]; end
      if (done8[g]) begin n = i; break; end
    end
  endtask

  task automatic b2b(input int g);
    int         n;
    logic       busy0;
    logic [7:0] s0;
    @(negedge iCLK);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; start8[g] = 1'b1;
    wait_done(g, n, busy0, s0);
    chk($sformatf("s%0d_b2b_lat1", 1 << g), n, (8 >> g) + 1);
    chk_result(g, 8'h12, 8'h34, 1'b0);
    // Restart from within the DONE cycle.
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start8[g] = 1'b1;
    wait_done(g, n, busy0, s0);
    chk($sformatf("s%0d_b2b_no_idle", 1 << g), busy0, 1'b1);
    chk($sformatf("s%0d_b2b_hold", 1 << g), s0, 8'h46);
    chk($sformatf("s%0d_b2b_lat2", 1 << g), n, (8 >> g) + 1);
    chk_result(g, 8'h80, 8'h80, 1'b0);
  endtask

  task automatic do_wide(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] full;
    logic [4:0]  lo;
    int          n;
    full = 17'(a) + 17'(b) + 17'(c);
    lo   = 5'(a[3:0]) + 5'(b[3:0]) + 5'(c);
    @(negedge iCLK);
    w_a = a; w_b = b; w_c = c; w_start = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge iCLK);
      w_start = 1'b0;
      if (wbus.oDONE) begin n = i; break; end
    end
    chk($sformatf("w16_lat_%h+%h", a, b), n, 3);
    chk($sformatf("w16_sum_%h+%h", a, b), wbus.oS, full[15:0]);
    chk($sformatf("w16_cy_%h+%h", a, b), wbus.oC, full[16]);
    chk($sformatf("w16_ac_%h+%h", a, b), wbus.oAC, lo[4]);
  endtask

  initial begin
    int ndone;
    iRSTn = 1'b0; start8 = '0; a8 = '0; b8 = '0; c8 = 1'b0;
    w_start = 1'b0; w_a = '0; w_b = '0; w_c = 1'b0;
    repeat (2) @(negedge iCLK);
    for (int g = 0; g < 4; g++)
      chk($sformatf("s%0d_reset", 1 << g), {s8[g], co8[g], ac8[g], busy8[g], done8[g]}, 12'h0);
    iRSTn = 1'b1;

    do_op(4'hF, 8'h3A, 8'h0C, 1'b0, 1'b0);
    do_op(4'hF, 8'hFF, 8'h00, 1'b1, 1'b0);
    do_op(4'hF, 8'h12, 8'h34, 1'b0, 1'b1);
    for (int g = 0; g < 4; g++) b2b(g);

    // Abort mid-RUN: outputs clear asynchronously and no completion follows.
    @(negedge iCLK);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; start8 = 4'b0011;
    for (int j = 0; j < 3; j++) begin
      @(negedge iCLK);
      start8 = 4'b0;
    end
    iRSTn = 1'b0;
    #1;
    for (int g = 0; g < 4; g++)
      chk($sformatf("s%0d_abort", 1 << g), {s8[g], co8[g], ac8[g], busy8[g], done8[g]}, 12'h0);
    repeat (2) @(negedge iCLK);
    iRSTn = 1'b1;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge iCLK);
      ndone += $countones(done8);
    end
    chk("abort_no_done", ndone, 0);
    for (int g = 0; g < 4; g++) begin exp_s[g] = '0; exp_c[g] = 1'b0; exp_ac[g] = 1'b0; end

    do_wide(16'h0FFF, 16'h0001, 1'b0);
    do_wide(16'hFFFF, 16'h0000, 1'b1);
    for (int i = 0; i < 40; i++) do_wide(16'($urandom), 16'($urandom), 1'($urandom));

    for (int i = 0; i < 1000; i++)
      do_op(4'hF, 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
